nv_fifo_128x11_ctrl: RTL and testbench

Synchronous 128-entry × 11-bit valid/ready FIFO controller built around the single-port-read/single-port-write RAM macro `nv_ram_rwsp_128x11`. It drives `we/wa/di` and `re/ra/ore`, and absorbs the macro's two-stage registered read latency (address register, then output register) with a 3-entry flop output buffer. The result is a 1-word/cycle streaming FIFO with backpressure.

---
 rtl/nv_fifo_pkg.sv | 19 +
 rtl/nv_fifo_obuf3x11.sv | 52 +++++
 rtl/nv_ram_rwsp_128x11.sv | 39 +++
 rtl/nv_fifo_128x11_ctrl.sv | 103 ++++++++++
 tb/tb_nv_fifo_128x11_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nv_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nv_fifo_pkg
// Brief   : Shared sizing constants and helpers for the 128x11 FIFO controller.
// Rev     : 1.0  initial release
// ============================================================================
package nv_fifo_pkg;
    localparam int DEPTH      = 128;
    localparam int WIDTH      = 11;
    localparam int AW         = 7;
    localparam int OBUF_DEPTH = 3;
    localparam int CNT_W      = 8;

    // Output-buffer pointers wrap at OBUF_DEPTH, not at a power of two.
    function automatic logic [1:0] obuf_next(input logic [1:0] p);
        return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction
endpackage
`default_nettype wire

// File: rtl/nv_fifo_obuf3x11.sv
`default_nettype none
// ============================================================================
// Module  : nv_fifo_obuf3x11
// Brief   : 3-entry flop FIFO that absorbs the RAM read latency.
// Rev     : 1.0  initial release
// ============================================================================
module nv_fifo_obuf3x11
    import nv_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);
    logic [WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [1:0]       r_wp;
    logic [1:0]       r_rp;
    logic [1:0]       r_cnt;

    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 2'd0;
        end else begin
            if (i_push) begin
                r_wp <= obuf_next(r_wp);
            end
            if (i_pop) begin
                r_rp <= obuf_next(r_rp);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/nv_ram_rwsp_128x11.sv
`default_nettype none
// ============================================================================
// Module  : nv_ram_rwsp_128x11
// Brief   : Behavioral model of the 128x11 RAM macro, registered address then
//           registered output (two-stage read).
// Rev     : 1.0  initial release
// ============================================================================
module nv_ram_rwsp_128x11 (
    input  logic        clk,
    input  logic        re,
    input  logic [6:0]  ra,
    input  logic        ore,
    output logic [10:0] dout,
    input  logic        we,
    input  logic [6:0]  wa,
    input  logic [10:0] di,
    input  logic [31:0] pwrbus_ram_pd
);
    logic [10:0] r_mem [128];
    logic [6:0]  r_ra;
    logic [10:0] r_dout;
    logic        w_pwr_unused;

    assign w_pwr_unused = ^pwrbus_ram_pd;
    assign dout         = r_dout;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= di;
        end
        if (re) begin
            r_ra <= ra;
        end
        if (ore) begin
            r_dout <= r_mem[r_ra];
        end
    end
endmodule
`default_nettype wire

// File: rtl/nv_fifo_128x11_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nv_fifo_128x11_ctrl
// Brief   : 128x11 valid/ready FIFO around a two-stage-read RAM macro.
// Rev     : 1.0  initial release
// ============================================================================
module nv_fifo_128x11_ctrl
    import nv_fifo_pkg::*;
(
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [CNT_W-1:0] fifo_cnt,
    input  logic [31:0]      pwrbus_ram_pd
);
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_ram_cnt;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic             r_s1_vld;
    logic             r_s2_vld;

    logic             w_wr;
    logic             w_pop;
    logic             w_re;
    logic             w_ore;
    logic             w_credit;
    logic [2:0]       w_inflight;
    logic [1:0]       w_ob_cnt;
    logic [WIDTH-1:0] w_ram_dout;

    // Ready depends only on registered state, never on the read side.
    assign wr_prdy  = !nvdla_core_rst && (r_ram_cnt != CNT_W'(DEPTH));
    assign rd_pvld  = !nvdla_core_rst && (w_ob_cnt != 2'd0);
    assign fifo_cnt = nvdla_core_rst ? '0 : r_fifo_cnt;

    assign w_wr  = wr_pvld && wr_prdy;
    assign w_pop = rd_pvld && rd_prdy;

    // Slots already promised to s1, s2 and the buffer, less the one leaving now.
    assign w_inflight = {2'b00, r_s1_vld} + {2'b00, r_s2_vld} + {1'b0, w_ob_cnt};
    assign w_credit   = w_inflight < (3'(OBUF_DEPTH) + {2'b00, w_pop});
    assign w_re       = !nvdla_core_rst && (r_ram_cnt != '0) && w_credit;
    assign w_ore      = !nvdla_core_rst && r_s1_vld;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_fifo_cnt <= '0;
            r_s1_vld   <= 1'b0;
            r_s2_vld   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_re})
                2'b10:   r_ram_cnt <= r_ram_cnt + CNT_W'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - CNT_W'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
            case ({w_wr, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            r_s1_vld <= w_re;
            r_s2_vld <= r_s1_vld;
        end
    end

    nv_ram_rwsp_128x11 u_ram (
        .clk           (nvdla_core_clk),
        .re            (w_re),
        .ra            (r_rd_ptr),
        .ore           (w_ore),
        .dout          (w_ram_dout),
        .we            (w_wr),
        .wa            (r_wr_ptr),
        .di            (wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    nv_fifo_obuf3x11 u_obuf (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .i_push  (r_s2_vld),
        .i_data  (w_ram_dout),
        .i_pop   (w_pop),
        .o_data  (rd_pd),
        .o_count (w_ob_cnt)
    );
endmodule
`default_nettype wire

// File: tb/tb_nv_fifo_128x11_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_nv_fifo_128x11_ctrl
// Brief   : Directed vectors plus multi-cycle sequences for the 128x11 FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nv_fifo_128x11_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [10:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [10:0] rd_pd;
    logic [7:0]  fifo_cnt;
    logic [31:0] pwrbus_ram_pd;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nv_fifo_128x11_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .fifo_cnt       (fifo_cnt),
        .pwrbus_ram_pd  (pwrbus_ram_pd)
    );

    typedef struct {
        logic        rst;
        logic        wv;
        logic [10:0] wd;
        logic        rr;
        logic        e_wrdy;
        logic        e_rvld;
        logic [10:0] e_pd;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tv [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [10:0] sb [$];
        logic [10:0] exp_d;
        int          acc;
        int          nexp;
        int          first;
        int          gaps;
        logic        prev_re;
        logic        hold;

        rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
        pwrbus_ram_pd = 32'h0;

        //           rst  wv   wd       rr    wrdy rvld pd       cnt
        tv[0]  = '{1'b1, 1'b1, 11'h111, 1'b1, 1'b0, 1'b0, 11'h000, 8'd0};
        tv[1]  = '{1'b0, 1'b1, 11'h5A5, 1'b0, 1'b1, 1'b0, 11'h000, 8'd0};
        tv[2]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[3]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[4]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[5]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h5A5, 8'd1};
        tv[6]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h5A5, 8'd1};
        tv[7]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd0};
        tv[8]  = '{1'b0, 1'b1, 11'h001, 1'b1, 1'b1, 1'b0, 11'h000, 8'd0};
        tv[9]  = '{1'b0, 1'b1, 11'h7FF, 1'b1, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[10] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd2};
        tv[11] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd2};
        tv[12] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h001, 8'd2};
        tv[13] = '{1'b0, 1'b1, 11'h3C3, 1'b1, 1'b1, 1'b1, 11'h7FF, 8'd1};
        tv[14] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[15] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[16] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd1};
        tv[17] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h3C3, 8'd1};
        tv[18] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 8'd0};

        step();
        step();

        for (int i = 0; i < 19; i++) begin
            rst = tv[i].rst; wr_pvld = tv[i].wv; wr_pd = tv[i].wd; rd_prdy = tv[i].rr;
            #2;
            chk($sformatf("vec%0d_wr_prdy", i), {31'd0, wr_prdy}, {31'd0, tv[i].e_wrdy});
            chk($sformatf("vec%0d_rd_pvld", i), {31'd0, rd_pvld}, {31'd0, tv[i].e_rvld});
            chk($sformatf("vec%0d_fifo_cnt", i), {24'd0, fifo_cnt}, {24'd0, tv[i].e_cnt});
            if (tv[i].e_rvld) begin
                chk($sformatf("vec%0d_rd_pd", i), {21'd0, rd_pd}, {21'd0, tv[i].e_pd});
            end
            step();
        end

        // Capacity with read side stalled, then full-RAM write racing a pop.
        do_reset();
        rd_prdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 140; c++) begin
            wr_pvld = 1'b1; wr_pd = 11'(acc);
            #2;
            if (wr_prdy) acc++;
            step();
        end
        chk("cap_accepted", acc, 131);
        wr_pvld = 1'b1; wr_pd = 11'd131;
        #2;
        chk("cap_wr_prdy", {31'd0, wr_prdy}, 32'd0);
        chk("cap_fifo_cnt", {24'd0, fifo_cnt}, 32'd131);
        step();
        rd_prdy = 1'b1;
        #2;
        chk("full_pop_wr_prdy", {31'd0, wr_prdy}, 32'd0);
        chk("full_pop_rd_pvld", {31'd0, rd_pvld}, 32'd1);
        chk("full_pop_rd_pd", {21'd0, rd_pd}, 32'd0);
        step();
        rd_prdy = 1'b0;
        #2;
        chk("full_next_wr_prdy", {31'd0, wr_prdy}, 32'd1);
        step();
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        nexp = 1;
        for (int c = 0; c < 400 && nexp < 132; c++) begin
            #2;
            if (rd_pvld) begin
                chk("drain_data", {21'd0, rd_pd}, 32'(nexp));
                nexp++;
            end
            step();
        end
        chk("drain_count", nexp, 132);
        #2;
        chk("drain_fifo_cnt", {24'd0, fifo_cnt}, 32'd0);
        step();

        // Continuous streaming, 300 words, pointers wrap twice.
        do_reset();
        rd_prdy = 1'b1;
        acc = 0; nexp = 0; first = -1; gaps = 0;
        for (int c = 0; c < 400 && nexp < 300; c++) begin
            wr_pvld = (acc < 300); wr_pd = 11'(acc);
            #2;
            if (rd_pvld) begin
                if (first < 0) first = c;
                chk("stream_data", {21'd0, rd_pd}, 32'(nexp));
                nexp++;
            end else if (first >= 0) begin
                gaps++;
            end
            if (wr_pvld && wr_prdy) acc++;
            step();
        end
        wr_pvld = 1'b0;
        chk("stream_first_pop_cycle", first, 4);
        chk("stream_gaps", gaps, 0);
        chk("stream_words", nexp, 300);

        // Random traffic against a scoreboard.
        do_reset();
        prev_re = 1'b0; hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                wr_pvld = 1'($urandom_range(0, 1));
                wr_pd   = 11'($urandom);
            end
            rd_prdy = 1'($urandom_range(0, 1));
            #2;
            chk("rand_fifo_cnt", {24'd0, fifo_cnt}, 32'(sb.size()));
            if (dut.w_ore && !prev_re) begin
                chk("rand_ore_without_re", 32'd1, 32'd0);
            end
            if (rd_pvld && rd_prdy) begin
                if (sb.size() == 0) begin
                    chk("rand_pop_empty", 32'd1, 32'd0);
                end else begin
                    exp_d = sb.pop_front();
                    chk("rand_data", {21'd0, rd_pd}, {21'd0, exp_d});
                end
            end
            if (wr_pvld && wr_prdy) sb.push_back(wr_pd);
            hold    = wr_pvld && !wr_prdy;
            prev_re = dut.w_re;
            step();
        end
        wr_pvld = 1'b0;

        // Reset mid-operation with reads in flight.
        do_reset();
        rd_prdy = 1'b0;
        for (int c = 0; c < 50; c++) begin
            wr_pvld = 1'b1; wr_pd = 11'(c + 200);
            step();
        end
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        step();
        step();
        rst = 1'b1;
        #2;
        chk("rst_hi_wr_prdy", {31'd0, wr_prdy}, 32'd0);
        chk("rst_hi_rd_pvld", {31'd0, rd_pvld}, 32'd0);
        chk("rst_hi_fifo_cnt", {24'd0, fifo_cnt}, 32'd0);
        step();
        rst = 1'b0; wr_pvld = 1'b1; wr_pd = 11'h123;
        #2;
        chk("post_rst_fifo_cnt", {24'd0, fifo_cnt}, 32'd0);
        chk("post_rst_rd_pvld", {31'd0, rd_pvld}, 32'd0);
        chk("post_rst_wr_prdy", {31'd0, wr_prdy}, 32'd1);
        step();
        wr_pvld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #2;
            chk($sformatf("post_rst_rd_pvld_c%0d", k), {31'd0, rd_pvld}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) begin
                chk("post_rst_rd_pd", {21'd0, rd_pd}, 32'h123);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
